ram_port_arbiter: RTL

//  Two-master arbiter in front of the single-port data RAM (req/gnt, 3-cycle grant).
//  M0 = instruction fetch (read-only word), M1 = load/store unit (full we/hb/uload).

---
 rtl/ram_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master req/gnt arbiter in front of the single-port data RAM, with a grant watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise M1 wins ties.
module ram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_hb_i,
    input  logic        m1_uload_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic [31:0] m1_rdata_o,
    output logic        ram_ce_o,
    output logic        ram_req_o,
    input  logic        ram_gnt_i,
    output logic        ram_we_o,
    output logic [1:0]  ram_hb_o,
    output logic        ram_uload_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        owner;
    logic        last;
    logic        err;
    logic [7:0]  wdog;
    logic        tie_pick;
    logic        winner;
    logic        busy;
    logic        expired;
    logic        done;
    logic [31:0] rdata_sel;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        tie_pick = ~last;
`else
        // last is kept current in both modes; fixed priority always picks M1.
        tie_pick = last | 1'b1;
`endif
        winner = (m0_req_i && m1_req_i) ? tie_pick : m1_req_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= 1'b0;
            wdog  <= 8'd0;
            err   <= 1'b0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        owner <= winner;
                        wdog  <= 8'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (ram_gnt_i) begin
                        state <= IDLE;
                        last  <= owner;
                    end else if (wdog == WDOG_LAST) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == BUSY);
    assign expired = busy && !ram_gnt_i && (wdog == WDOG_LAST);
    assign done    = (busy && ram_gnt_i) || expired;

    assign ram_req_o = busy;
    assign ram_ce_o  = busy;
    assign err_o     = err;

    // A watchdog release returns zero data rather than whatever the RAM has on its bus.
    assign rdata_sel  = (busy && ram_gnt_i) ? ram_rdata_i : 32'h0;
    assign m0_gnt_o   = done && !owner;
    assign m1_gnt_o   = done && owner;
    assign m0_rdata_o = m0_gnt_o ? rdata_sel : 32'h0;
    assign m1_rdata_o = m1_gnt_o ? rdata_sel : 32'h0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_hb_o    = 2'b00;
        ram_uload_o = 1'b0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        if (busy) begin
            if (owner) begin
                ram_we_o    = m1_we_i;
                ram_hb_o    = m1_hb_i;
                ram_uload_o = m1_uload_i;
                ram_addr_o  = m1_addr_i;
                ram_wdata_o = m1_wdata_i;
            end else begin
                ram_hb_o   = 2'b10;
                ram_addr_o = m0_addr_i;
            end
        end
    end

endmodule
